// File: rtl/mips_muldiv_ctrl_if.sv
// EX <-> iterative HI/LO multiply/divide sequencer bundle.
// master = EX pipeline side, slave = mips_muldiv_ctrl.
interface mips_muldiv_ctrl_if;
    // Handshake: md_req_valid is honoured only while md_ready is high (IDLE). A
    // request is accepted on the rising edge where md_req_valid=1, md_ready=1 and
    // md_cancel=0. Operands and op are captured at that edge and may change
    // afterwards. md_busy covers the MUL, DIV and FIX cycles. One md_*_complete
    // output stays high, with md_hi/md_lo stable, until md_ack is sampled high.
    // The unit returns to IDLE one cycle after that. md_cancel aborts from any
    // state and wins over md_req_valid and md_ack.
    logic        md_req_valid;
    logic [1:0]  md_op;
    logic [31:0] md_src_a;
    logic [31:0] md_src_b;
    logic        md_cancel;
    logic        md_ack;
    logic        md_ready;
    logic        md_busy;
    logic        md_mult_complete;
    logic        md_div_complete;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    modport master (
        output md_req_valid, md_op, md_src_a, md_src_b, md_cancel, md_ack,
        input  md_ready, md_busy, md_mult_complete, md_div_complete, md_hi, md_lo
    );

    modport slave (
        input  md_req_valid, md_op, md_src_a, md_src_b, md_cancel, md_ack,
        output md_ready, md_busy, md_mult_complete, md_div_complete, md_hi, md_lo
    );
endinterface

// File: rtl/mips_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer holding HI/LO until EX retires it.
// Define MD_EARLY_OUT_EN to let MUL exit as soon as the remaining multiplier is zero.
module mips_muldiv_ctrl #(
    parameter int          MUL_STEP    = 1,
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_muldiv_ctrl_if.slave         md,
    output logic [2:0]                o_dbg_state
);

    localparam int         N_MUL    = 32 / MUL_STEP;
    localparam logic [5:0] MUL_LAST = 6'(N_MUL - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_div_zero;
    logic [31:0] r_a_raw;
    logic [5:0]  r_cnt;
    logic [63:0] r_mcand;
    logic [32:0] r_mplier;
    logic [63:0] r_acc;
    logic [32:0] r_divisor;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed_op;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [32:0] w_a_mag;
    logic [32:0] w_b_mag;
    logic [63:0] w_acc_next;
    logic [32:0] w_mplier_next;
    logic        w_mul_exit;
    logic [32:0] w_shift;
    logic [32:0] w_sub;
    logic        w_ge;
    logic [63:0] w_prod;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_unused_sub;

    // Operand magnitudes are 33 bits so |0x80000000| and unsigned 0xFFFFFFFF both fit.
    assign w_signed_op = ~md.md_op[0];
    assign w_a_neg     = w_signed_op & md.md_src_a[31];
    assign w_b_neg     = w_signed_op & md.md_src_b[31];
    assign w_a_mag     = w_a_neg ? (33'd0 - {md.md_src_a[31], md.md_src_a}) : {1'b0, md.md_src_a};
    assign w_b_mag     = w_b_neg ? (33'd0 - {md.md_src_b[31], md.md_src_b}) : {1'b0, md.md_src_b};

    always_comb begin
        w_acc_next = r_acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (r_mplier[j]) begin
                w_acc_next = w_acc_next + (r_mcand << j);
            end
        end
    end

    assign w_mplier_next = r_mplier >> MUL_STEP;

`ifdef MD_EARLY_OUT_EN
    assign w_mul_exit = (r_cnt == MUL_LAST) || (w_mplier_next == 33'd0);
`else
    assign w_mul_exit = (r_cnt == MUL_LAST);
`endif

    // Restoring divide: the dividend shifts out of r_quo MSB first while quotient bits shift in.
    assign w_shift      = {r_rem, r_quo[31]};
    assign w_ge         = (w_shift >= r_divisor);
    assign w_sub        = w_shift - r_divisor;
    assign w_unused_sub = w_sub[32];

    assign w_prod    = r_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quo_fix = r_neg_res ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix = r_neg_rem ? (32'd0 - r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= 32'd0;
            r_cnt      <= 6'd0;
            r_mcand    <= 64'd0;
            r_mplier   <= 33'd0;
            r_acc      <= 64'd0;
            r_divisor  <= 33'd0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else if (md.md_cancel) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (md.md_req_valid) begin
                        r_is_div   <= md.md_op[1];
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= md.md_op[1] && (md.md_src_b == 32'd0);
                        r_a_raw    <= md.md_src_a;
                        r_cnt      <= 6'd0;
                        r_mcand    <= {31'd0, w_a_mag};
                        r_mplier   <= w_b_mag;
                        r_acc      <= 64'd0;
                        r_divisor  <= w_b_mag;
                        r_rem      <= 32'd0;
                        r_quo      <= w_a_mag[31:0];
                        if (!md.md_op[1]) begin
                            r_state <= S_MUL;
                        end else if (md.md_src_b == 32'd0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << MUL_STEP;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 6'd1;
                    if (w_mul_exit) begin
                        r_state <= S_FIX;
                    end
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_sub[31:0] : w_shift[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == DIV_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_div_zero) begin
                        r_hi <= r_a_raw;
                        r_lo <= DIV_ZERO_LO;
                    end else if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (md.md_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign md.md_ready         = (r_state == S_IDLE);
    assign md.md_busy          = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
    assign md.md_mult_complete = (r_state == S_DONE) && !r_is_div;
    assign md.md_div_complete  = (r_state == S_DONE) && r_is_div;
    assign md.md_hi            = r_hi;
    assign md.md_lo            = r_lo;
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Randomized bench for mips_muldiv_ctrl with an arithmetic reference model.
// Covers directed corner operations, cancel, reset mid-operation and DONE hold/ack behaviour.
module tb_mips_muldiv_ctrl;

    localparam int          MUL_STEP = 1;
    localparam int          N_MUL    = 32 / MUL_STEP;
    localparam logic [31:0] DZ_LO    = 32'hFFFFFFFF;

    logic        clk;
    logic        rst;
    logic [2:0]  dbg_state;
    int          n_cmp;
    int          n_err;
    logic [63:0] exp_q[$];
    logic [63:0] last_hl;

    mips_muldiv_ctrl_if md_if();

    mips_muldiv_ctrl #(
        .MUL_STEP    (MUL_STEP),
        .DIV_ZERO_LO (DZ_LO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .md          (md_if),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hi, lo} computed from plain 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, q, r;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        res = 64'd0;
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, DZ_LO};
                end else begin
                    if (op == 2'b10) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = ua / ub;
                        r = ua % ub;
                    end
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint mag;
        int     bl;
        int     iters;
        if (op[1]) return (b == 32'd0) ? 2 : 34;
        mag = (op == 2'b00) ? longint'($signed(b)) : longint'({32'd0, b});
        if (mag < 0) mag = -mag;
        bl = 0;
        for (int i = 0; i < 33; i++) if (mag[i]) bl = i + 1;
        iters = N_MUL;
`ifdef MD_EARLY_OUT_EN
        iters = (bl == 0) ? 1 : (bl + MUL_STEP - 1) / MUL_STEP;
`endif
        if (a == 32'hDEADBEEF && bl < 0) iters = 0;
        return iters + 2;
    endfunction

    task automatic idle_inputs();
        md_if.md_req_valid = 1'b0;
        md_if.md_cancel    = 1'b0;
        md_if.md_ack       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge while the DUT is IDLE; that cycle is cycle 0.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit ack_with_req);
        int          cyc;
        int          busy_cnt;
        int          exp_lat;
        int          nh;
        bit          done;
        logic [63:0] exp_hl;
        logic [63:0] held;
        exp_q.push_back(model(op, a, b));
        exp_lat = latency(op, a, b);
        check("ready_before_accept", {63'd0, md_if.md_ready}, 64'd1);
        md_if.md_req_valid = 1'b1;
        md_if.md_op        = op;
        md_if.md_src_a     = a;
        md_if.md_src_b     = b;
        cyc = 0;
        busy_cnt = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                md_if.md_req_valid = 1'b0;
                md_if.md_op        = 2'($urandom_range(0, 3));
                md_if.md_src_a     = $urandom;
                md_if.md_src_b     = $urandom;
            end
            if (md_if.md_busy) busy_cnt++;
            if (md_if.md_mult_complete || md_if.md_div_complete) done = 1'b1;
            md_if.md_ack = done ? 1'b0 : 1'($urandom_range(0, 1));
        end
        md_if.md_ack = 1'b0;
        check("complete_seen", {63'd0, done}, 64'd1);
        check("latency", 64'(cyc), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
        check("complete_kind", {62'd0, md_if.md_div_complete, md_if.md_mult_complete},
              op[1] ? 64'd2 : 64'd1);
        exp_hl = exp_q.pop_front();
        check("hi_lo", {md_if.md_hi, md_if.md_lo}, exp_hl);
        last_hl = exp_hl;
        held = {md_if.md_hi, md_if.md_lo};
        nh = $urandom_range(0, 3);
        for (int k = 0; k < nh; k++) begin
            tick();
            check("done_hold_complete", {63'd0, md_if.md_mult_complete | md_if.md_div_complete}, 64'd1);
            check("done_hold_hilo", {md_if.md_hi, md_if.md_lo}, held);
        end
        md_if.md_ack = 1'b1;
        if (ack_with_req) begin
            md_if.md_req_valid = 1'b1;
            md_if.md_src_b     = 32'd7;
        end
        tick();
        idle_inputs();
        check("idle_after_ack", {61'd0, md_if.md_ready, md_if.md_busy,
              md_if.md_mult_complete | md_if.md_div_complete}, 64'd4);
    endtask

    task automatic cancel_test(input int at_cycle);
        int cyc;
        md_if.md_req_valid = 1'b1;
        md_if.md_op        = 2'b10;
        md_if.md_src_a     = $urandom;
        md_if.md_src_b     = $urandom | 32'd1;
        cyc = 0;
        while (cyc < at_cycle) begin
            tick();
            cyc++;
            md_if.md_req_valid = 1'b0;
            check("cancel_no_early_complete",
                  {63'd0, md_if.md_mult_complete | md_if.md_div_complete}, 64'd0);
        end
        md_if.md_cancel = 1'b1;
        md_if.md_ack    = 1'b1;
        tick();
        idle_inputs();
        check("cancel_ready", {63'd0, md_if.md_ready}, 64'd1);
        check("cancel_no_complete", {63'd0, md_if.md_mult_complete | md_if.md_div_complete}, 64'd0);
        check("cancel_hilo_kept", {md_if.md_hi, md_if.md_lo}, last_hl);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_hl = 64'd0;
        rst = 1'b1;
        idle_inputs();
        md_if.md_op    = 2'b00;
        md_if.md_src_a = 32'd0;
        md_if.md_src_b = 32'd0;
        repeat (3) tick();
        check("reset_flags", {60'd0, md_if.md_ready, md_if.md_busy,
              md_if.md_mult_complete, md_if.md_div_complete}, 64'd8);
        check("reset_hilo", {md_if.md_hi, md_if.md_lo}, 64'd0);
        rst = 1'b0;
        tick();

        run_op(2'b00, 32'hFFFFFFFF, 32'd5, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(2'b11, 32'd10, 32'd0, 1'b1);
        run_op(2'b10, 32'h80000000, 32'd0, 1'b0);
        run_op(2'b01, 32'd3, 32'd2, 1'b0);
        run_op(2'b00, 32'h80000000, 32'h80000000, 1'b0);
        run_op(2'b00, 32'd12345, 32'd0, 1'b0);

        cancel_test(10);
        run_op(2'b01, 32'd77, 32'd9, 1'b0);

        md_if.md_req_valid = 1'b1;
        md_if.md_cancel    = 1'b1;
        tick();
        idle_inputs();
        check("cancel_beats_req", {62'd0, md_if.md_ready, md_if.md_busy}, 64'd2);

        md_if.md_req_valid = 1'b1;
        md_if.md_op        = 2'b00;
        md_if.md_src_a     = 32'h1234;
        md_if.md_src_b     = 32'h5678;
        repeat (5) begin
            tick();
            md_if.md_req_valid = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_mul_ready", {62'd0, md_if.md_ready, md_if.md_busy}, 64'd2);
        check("rst_mid_mul_hilo", {md_if.md_hi, md_if.md_lo}, 64'd0);
        last_hl = 64'd0;

        for (int t = 0; t < 40; t++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = 32'($urandom_range(0, 15));
                4: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                cancel_test($urandom_range(1, 30));
            end
            run_op(op, a, b, 1'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
